// File: rtl/pll_reconfig_seq_if.sv
// pll_reconfig_seq_if: Avalon-MM write-only reconfiguration management bus
// between the sequencer (master) and the pll_cfg reconfig block (slave).
interface pll_reconfig_seq_if;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic        write;
  logic        waitrequest;

  modport master (output address, output writedata, output write, input waitrequest);
  modport slave  (input address, input writedata, input write, output waitrequest);
endinterface

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: runs the eight-write PLL reconfiguration for a preset,
// pulses the PLL reset and waits for lock before reporting completion.
// Optional feature macro: PLLSEQ_LOCK_TIMEOUT_EN adds a lock-wait timeout
// that returns to idle with a one-cycle error pulse.
//
//   state    | meaning
//   IDLE     | ready, waiting for req
//   WRITE    | mgmt write strobe high until waitrequest drops
//   GAP      | SETTLE idle cycles after each completed write
//   PRST     | pll_reset high for RESET_CYCLES cycles
//   HOLDOFF  | LOCK_HOLDOFF cycles with pll_locked ignored
//   LOCKWAIT | waiting for pll_locked
module pll_reconfig_seq #(
  parameter int NUM_PRESETS  = 38,
  parameter int SETTLE       = 8,
  parameter int RESET_CYCLES = 2,
  parameter int LOCK_HOLDOFF = 16,
  parameter int LOCK_TIMEOUT = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic [5:0]           preset,
  output logic                 ready,
  output logic                 done,
  output logic                 error,
  output logic [5:0]           cur_preset,
  output logic [5:0]           tbl_idx,
  input  logic [31:0]          tbl_m,
  input  logic [31:0]          tbl_k,
  input  logic [31:0]          tbl_c0,
  pll_reconfig_seq_if.master   mgmt,
  input  logic                 pll_locked,
  output logic                 pll_reset
);

  typedef enum logic [2:0] {IDLE, WRITE, GAP, PRST, HOLDOFF, LOCKWAIT} state_t;

  // One shared down-counter covers gap, reset and holdoff; it only ever holds
  // (length - 1), so its width comes from the largest of the three lengths.
  localparam int CNT_MAX = (SETTLE > RESET_CYCLES)
                           ? ((SETTLE > LOCK_HOLDOFF) ? SETTLE : LOCK_HOLDOFF)
                           : ((RESET_CYCLES > LOCK_HOLDOFF) ? RESET_CYCLES : LOCK_HOLDOFF);
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [5:0] LAST_PRESET = 6'(NUM_PRESETS - 1);

  // Every counter is loaded with (length - 1), so zero lengths cannot work.
  if (SETTLE < 1 || RESET_CYCLES < 1 || LOCK_HOLDOFF < 1 || LOCK_TIMEOUT < 1 ||
      NUM_PRESETS < 1 || NUM_PRESETS > 64) begin : g_bad_params
    $error("pll_reconfig_seq: parameter out of range");
  end

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_val;
  logic [2:0]    widx;
  logic          cnt_load, accept, lock_ok, widx_inc, done_q;

`ifdef PLLSEQ_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit, timeout, err_q;

  assign tmo_hit = (tmo_cnt == '0);
  assign error   = err_q;

  // Lock-wait timer: preloaded outside LOCKWAIT, counts down while waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state != LOCKWAIT)
        tmo_cnt <= TW'(LOCK_TIMEOUT - 1);
      else if (!tmo_hit)
        tmo_cnt <= tmo_cnt - 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

  assign done = done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath registers: latched preset, write index, shared timer, result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      widx       <= 3'd0;
      tbl_idx    <= 6'd0;
      cur_preset <= 6'd0;
      done_q     <= 1'b0;
    end else begin
      done_q <= lock_ok;
      if (accept) begin
        tbl_idx <= (preset > LAST_PRESET) ? LAST_PRESET : preset;
        widx    <= 3'd0;
      end else if (widx_inc) begin
        widx <= widx + 3'd1;
      end
      if (cnt_load)         cnt <= cnt_val;
      else if (cnt != '0)   cnt <= cnt - 1'b1;
      if (lock_ok)          cur_preset <= tbl_idx;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next     = state;
    ready          = 1'b0;
    pll_reset      = 1'b0;
    mgmt.write     = 1'b0;
    mgmt.address   = 6'd0;
    mgmt.writedata = 32'd0;
    cnt_load       = 1'b0;
    cnt_val        = '0;
    accept         = 1'b0;
    lock_ok        = 1'b0;
    widx_inc       = 1'b0;
`ifdef PLLSEQ_LOCK_TIMEOUT_EN
    timeout        = 1'b0;
`endif
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          accept     = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        mgmt.write = 1'b1;
        case (widx)
          3'd0: begin mgmt.address = 6'd0; mgmt.writedata = 32'd0;       end
          3'd1: begin mgmt.address = 6'd4; mgmt.writedata = tbl_m;       end
          3'd2: begin mgmt.address = 6'd7; mgmt.writedata = tbl_k;       end
          3'd3: begin mgmt.address = 6'd3; mgmt.writedata = 32'h10000;   end
          3'd4: begin mgmt.address = 6'd5; mgmt.writedata = tbl_c0;      end
          3'd5: begin mgmt.address = 6'd9; mgmt.writedata = 32'd1;       end
          3'd6: begin mgmt.address = 6'd8; mgmt.writedata = 32'd7;       end
          default: begin mgmt.address = 6'd2; mgmt.writedata = 32'd0;    end
        endcase
        if (!mgmt.waitrequest) begin
          state_next = GAP;
          cnt_load   = 1'b1;
          cnt_val    = CW'(SETTLE - 1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (widx == 3'd7) begin
            state_next = PRST;
            cnt_load   = 1'b1;
            cnt_val    = CW'(RESET_CYCLES - 1);
          end else begin
            state_next = WRITE;
            widx_inc   = 1'b1;
          end
        end
      end
      PRST: begin
        pll_reset = 1'b1;
        if (cnt == '0) begin
          state_next = HOLDOFF;
          cnt_load   = 1'b1;
          cnt_val    = CW'(LOCK_HOLDOFF - 1);
        end
      end
      HOLDOFF: begin
        if (cnt == '0) state_next = LOCKWAIT;
      end
      LOCKWAIT: begin
        if (pll_locked) begin
          lock_ok    = 1'b1;
          state_next = IDLE;
        end
`ifdef PLLSEQ_LOCK_TIMEOUT_EN
        else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb_pll_reconfig_seq: table-driven and randomized checks of the PLL
// reconfiguration sequencer against a transaction-level expectation model.
module tb_pll_reconfig_seq;
  localparam int SETTLE = 8, RESET_CYCLES = 2, LOCK_HOLDOFF = 16, TMO = 100, NUMP = 38;
  localparam int WSLOT   = 1 + SETTLE;
  localparam int PRST_AT = 8 * WSLOT;
  localparam int NOM_LAT = 8 * WSLOT + RESET_CYCLES + LOCK_HOLDOFF + 1;

  logic clk = 1'b0, reset = 1'b1, req = 1'b0, pll_locked = 1'b1;
  logic [5:0] preset = 6'd0;
  logic ready, done, error, pll_reset;
  logic [5:0] cur_preset, tbl_idx;
  logic [31:0] tbl_m, tbl_k, tbl_c0;
  logic [31:0] tm [64], tk [64], tc0 [64];

  pll_reconfig_seq_if mgmt();

  assign tbl_m  = tm[tbl_idx];
  assign tbl_k  = tk[tbl_idx];
  assign tbl_c0 = tc0[tbl_idx];

  pll_reconfig_seq #(.NUM_PRESETS(NUMP), .SETTLE(SETTLE), .RESET_CYCLES(RESET_CYCLES),
                     .LOCK_HOLDOFF(LOCK_HOLDOFF), .LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .preset(preset), .ready(ready), .done(done),
    .error(error), .cur_preset(cur_preset), .tbl_idx(tbl_idx), .tbl_m(tbl_m),
    .tbl_k(tbl_k), .tbl_c0(tbl_c0), .mgmt(mgmt), .pll_locked(pll_locked),
    .pll_reset(pll_reset));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; logic [31:0] data; int hold; int wcum; } wr_rec_t;
  wr_rec_t wr_q [$];
  int rst_q [$], done_q [$], err_q [$];
  int wait_mode = 0, wait_addr = 0, wait_left = 0, wait_total = 0;
  int hold = 0, stable_bad = 0;
  logic [5:0]  hold_addr;
  logic [31:0] hold_data;
  int checks = 0, errors = 0, model_cur = 0;
  int exp_addr_tab [8] = '{0, 4, 7, 3, 5, 9, 8, 2};

  // Slave side: drives waitrequest for the next edge and logs bus/PLL activity.
  always @(negedge clk) begin
    logic wr;
    wr = 1'b0;
    if (mgmt.write) begin
      if (wait_mode == 1 && int'(mgmt.address) == wait_addr && wait_left > 0) begin
        wr = 1'b1; wait_left--;
      end else if (wait_mode == 2 && wait_total < 6 && $urandom_range(0, 2) == 0)
        wr = 1'b1;
    end
    mgmt.waitrequest = wr;
    if (mgmt.write) begin
      if (hold == 0) begin hold_addr = mgmt.address; hold_data = mgmt.writedata; end
      else if (mgmt.address != hold_addr || mgmt.writedata != hold_data) stable_bad++;
      hold++;
      if (wr) wait_total++;
      else begin
        wr_q.push_back('{cyc, int'(mgmt.address), mgmt.writedata, hold, wait_total});
        hold = 0;
      end
    end
    if (pll_reset) rst_q.push_back(cyc);
    if (done)      done_q.push_back(cyc);
    if (error)     err_q.push_back(cyc);
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int i, input int idx);
    case (i)
      1: return tm[idx];
      2: return tk[idx];
      3: return 32'h10000;
      4: return tc0[idx];
      5: return 32'd1;
      6: return 32'd7;
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_mon(input int wm, input int wa, input int wn);
    wr_q.delete(); rst_q.delete(); done_q.delete(); err_q.delete();
    wait_total = 0; hold = 0; stable_bad = 0;
    wait_mode = wm; wait_addr = wa; wait_left = wn;
  endtask

  // One full request; exp_lat < 0 means nominal latency plus observed wait states.
  task automatic run_seq(input logic [5:0] p, input int exp_idx, input int exp_lat,
                         input int ign_after, input string nm);
    int k, start, n, w, lat, prev;
    @(negedge clk);
    check({nm, " ready_before"}, ready, 1);
    req = 1'b1; preset = p; k = cyc;
    @(negedge clk);
    req = 1'b0; preset = 6'($urandom);
    start = k + 1; n = 0;
    while (!done && n < 3000) begin
      @(negedge clk); n++;
      if (ign_after > 0 && n == ign_after) begin req = 1'b1; preset = 6'd9; end
      else req = 1'b0;
    end
    req = 1'b0;
    repeat (3) @(negedge clk);
    w = wait_total;
    lat = (exp_lat < 0) ? NOM_LAT + w : exp_lat;
    check({nm, " done_count"}, done_q.size(), 1);
    if (done_q.size() > 0) check({nm, " done_latency"}, done_q[0] - start, lat);
    check({nm, " write_count"}, wr_q.size(), 8);
    prev = 0;
    for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
      check({nm, $sformatf(" w%0d_addr", i)}, wr_q[i].addr, exp_addr_tab[i]);
      check({nm, $sformatf(" w%0d_data", i)}, wr_q[i].data, exp_data(i, exp_idx));
      check({nm, $sformatf(" w%0d_cycle", i)}, wr_q[i].cyc - start, i * WSLOT + wr_q[i].wcum);
      check({nm, $sformatf(" w%0d_hold", i)}, wr_q[i].hold, 1 + wr_q[i].wcum - prev);
      prev = wr_q[i].wcum;
    end
    check({nm, " stable"}, stable_bad, 0);
    check({nm, " prst_len"}, rst_q.size(), RESET_CYCLES);
    if (rst_q.size() > 0) check({nm, " prst_start"}, rst_q[0] - start, PRST_AT + w);
    if (rst_q.size() > 1) check({nm, " prst_contig"}, rst_q[1] - rst_q[0], 1);
    check({nm, " tbl_idx"}, tbl_idx, exp_idx);
    check({nm, " cur_preset"}, cur_preset, exp_idx);
    check({nm, " ready_after"}, ready, 1);
    model_cur = exp_idx;
  endtask

  typedef struct { logic [5:0] p; int wmode; int waddr; int wn; int exp_idx; int exp_lat; } vec_t;
  vec_t vecs [6];

  initial begin
    int k, start, n, d, pr;
    logic [5:0] rp;
    vecs[0] = '{6'd5,  0, 0, 0, 5,  91};
    vecs[1] = '{6'd5,  1, 7, 3, 5,  94};
    vecs[2] = '{6'd37, 1, 0, 1, 37, 92};
    vecs[3] = '{6'd50, 0, 0, 0, 37, 91};
    vecs[4] = '{6'd63, 1, 2, 2, 37, 93};
    vecs[5] = '{6'd0,  1, 9, 5, 0,  96};
    for (int i = 0; i < 64; i++) begin tm[i] = $urandom; tk[i] = $urandom; tc0[i] = $urandom; end

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst ready", ready, 1);
    check("rst done", done, 0);
    check("rst error", error, 0);
    check("rst write", mgmt.write, 0);
    check("rst address", mgmt.address, 0);
    check("rst writedata", mgmt.writedata, 0);
    check("rst pll_reset", pll_reset, 0);
    check("rst tbl_idx", tbl_idx, 0);
    check("rst cur_preset", cur_preset, 0);
    reset = 1'b0;

    // Reset asserted while pll_reset is high aborts without done.
    clear_mon(0, 0, 0);
    @(negedge clk); req = 1'b1; preset = 6'd12;
    @(negedge clk); req = 1'b0; n = 0;
    while (!pll_reset && n < 300) begin @(negedge clk); n++; end
    check("abort reached_prst", pll_reset, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort pll_reset", pll_reset, 0);
    check("abort write", mgmt.write, 0);
    check("abort ready", ready, 1);
    check("abort cur_preset", cur_preset, 0);
    check("abort done", done, 0);
    reset = 1'b0; model_cur = 0;
    clear_mon(0, 0, 0);
    repeat (150) @(negedge clk);
    check("abort no_done", done_q.size(), 0);
    check("abort no_writes", wr_q.size(), 0);

    // Table-driven vectors.
    for (int v = 0; v < 6; v++) begin
      clear_mon(vecs[v].wmode, vecs[v].waddr, vecs[v].wn);
      run_seq(vecs[v].p, vecs[v].exp_idx, vecs[v].exp_lat, 0, $sformatf("vec%0d", v));
      if (vecs[v].wmode == 1)
        for (int i = 0; i < wr_q.size(); i++)
          if (wr_q[i].addr == vecs[v].waddr)
            check($sformatf("vec%0d held_write", v), wr_q[i].hold, vecs[v].wn + 1);
    end

    // req during GAP is dropped, not queued.
    clear_mon(0, 0, 0);
    run_seq(6'd11, 11, NOM_LAT, 22, "ignore");

    // Randomized presets and wait states.
    for (int r = 0; r < 6; r++) begin
      rp = 6'($urandom_range(0, 63));
      clear_mon(2, 0, 0);
      run_seq(rp, (int'(rp) > NUMP - 1) ? NUMP - 1 : int'(rp), -1, 0, $sformatf("rnd%0d", r));
    end

    // Back-to-back with req held high.
    clear_mon(0, 0, 0);
    @(negedge clk); req = 1'b1; preset = 6'd1; n = 0;
    @(negedge clk);
    while (!done && n < 3000) begin @(negedge clk); n++; end
    check("b2b first_done", done, 1);
    d = cyc; preset = 6'd2;
    @(negedge clk);
    check("b2b restart_write", mgmt.write, 1);
    check("b2b restart_addr", mgmt.address, 0);
    check("b2b restart_cycle", cyc - d, 1);
    check("b2b cur_first", cur_preset, 1);
    check("b2b tbl_idx", tbl_idx, 2);
    req = 1'b0; n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("b2b done_count", done_q.size(), 2);
    if (done_q.size() > 1) check("b2b second_latency", done_q[1] - done_q[0], NOM_LAT + 1);
    check("b2b cur_second", cur_preset, 2);
    check("b2b writes", wr_q.size(), 16);
    model_cur = 2;

    // Lock never arrives.
    clear_mon(0, 0, 0);
    pll_locked = 1'b0; pr = model_cur;
    @(negedge clk); req = 1'b1; preset = 6'd20; k = cyc;
    @(negedge clk); req = 1'b0; start = k + 1; n = 0;
`ifdef PLLSEQ_LOCK_TIMEOUT_EN
    while (!error && n < 1000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("tmo error_count", err_q.size(), 1);
    if (err_q.size() > 0)
      check("tmo error_cycle", err_q[0] - start, PRST_AT + RESET_CYCLES + LOCK_HOLDOFF + TMO);
    check("tmo no_done", done_q.size(), 0);
    check("tmo cur_preset", cur_preset, pr);
    check("tmo ready", ready, 1);
    pll_locked = 1'b1;
`else
    repeat (10000) @(negedge clk);
    check("nolock error", err_q.size(), 0);
    check("nolock no_done", done_q.size(), 0);
    check("nolock busy", ready, 0);
    check("nolock pll_reset", pll_reset, 0);
    check("nolock cur_preset", cur_preset, pr);
    pll_locked = 1'b1; n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check("nolock late_done", done_q.size(), 1);
    check("nolock cur_after", cur_preset, 20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
